// File: rtl/ram_bus_arbiter.sv
// Two-master req/ack arbiter in front of a single-port data RAM (CPU datapath vs loader/DMA).
// Optional macro ARB_M0_PRIO_EN: fixed m0 priority on ties instead of round-robin.
module ram_bus_arbiter #(
  parameter int AW     = 13,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_gnt;
  logic          win;
  logic          wr_q;
  logic          pick;
  logic          any_req;
  logic          wait_done;
  logic [CW-1:0] cnt;

  assign any_req   = m0_req | m1_req;
  assign wait_done = (cnt == CW'(RD_LAT - 1));

  // pick = 1 selects m1; round-robin favours the master that did not win last time
  always_comb begin
    pick = 1'b0;
`ifdef ARB_M0_PRIO_EN
    pick = ~m0_req;
`else
    if (m0_req && m1_req)
      pick = ~last_gnt;
    else
      pick = ~m0_req;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = wr_q ? ACK : WAIT;
      WAIT:    if (wait_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      win       <= 1'b0;
      wr_q      <= 1'b0;
      cnt       <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        win       <= pick;
        last_gnt  <= pick;
        wr_q      <= pick ? m1_wr    : m0_wr;
        ram_addr  <= pick ? m1_addr  : m0_addr;
        ram_wdata <= pick ? m1_wdata : m0_wdata;
      end
      // ram_rdata is valid in the last WAIT cycle; capture it for the winner only
      if (state == WAIT) begin
        if (wait_done) begin
          cnt <= '0;
          if (win)
            m1_rdata <= ram_rdata;
          else
            m0_rdata <= ram_rdata;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign ram_en = (state == ACCESS);
  assign ram_wr = ram_en & wr_q;
  assign m0_ack = (state == ACK) & ~win;
  assign m1_ack = (state == ACK) & win;
  assign busy   = (state != IDLE);

endmodule
